// File: rtl/data_mem_slave.sv
// Single-port data memory slave on the load/store data bus.
// Accepts one request per cycle, applies byte-enabled writes, and returns
// read data plus the echoed destination tag after LATENCY cycles.
// After reset it can zero-fill storage before granting any request.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero-filling one word per cycle; no grants, busy_o high
// ST_READY | normal operation; data_gnt_o follows data_req_i
module data_mem_slave #(
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        req,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic [31:0] data_add_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  input  logic        data_we_i,
  input  logic [4:0]  rd_in,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [4:0]  rd_out,
  output logic        data_err_o,
  output logic        busy_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            clr_we;
  logic            gnt;
  logic            busy;

  logic [31:0]     mem_q [DEPTH];

  logic [AW-1:0]   word_idx;
  logic            in_range;
  logic            acc_rd;
  logic            acc_wr;

  logic            pipe_vld_q [LATENCY];
  logic [31:0]     pipe_dat_q [LATENCY];
  logic [4:0]      pipe_tag_q [LATENCY];
  logic            pipe_err_q [LATENCY];
  logic            werr_q;

  // State and clear-counter registers
  always_ff @(posedge req) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic, grant and clear-write control
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    gnt       = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        clr_we    = ~reset;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // reset has priority, so a request in the reset cycle is not accepted
        gnt = data_req_i & ~reset;
      end
      default: state_d = ST_READY;
    endcase
  end

  assign word_idx = data_add_i[AW+1:2];
  // full-width compare: large addresses are errors, never aliased
  assign in_range = (data_add_i < ADDR_LIMIT);
  assign acc_rd   = gnt & ~data_we_i;
  assign acc_wr   = gnt & data_we_i;

  // Storage: zero-fill during clear, byte-enabled writes otherwise; never reset
  always_ff @(posedge req) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (acc_wr && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read-response pipeline and write-error flag; flushed on reset
  always_ff @(posedge req) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
        pipe_tag_q[i] <= '0;
        pipe_err_q[i] <= 1'b0;
      end
      werr_q <= 1'b0;
    end else begin
      pipe_vld_q[0] <= acc_rd;
      pipe_dat_q[0] <= (acc_rd && in_range) ? mem_q[word_idx] : 32'h0;
      pipe_tag_q[0] <= acc_rd ? rd_in : 5'h0;
      pipe_err_q[0] <= acc_rd & ~in_range;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
      werr_q <= acc_wr & ~in_range;
    end
  end

  assign data_gnt_o    = gnt;
  assign busy_o        = busy;
  assign data_rvalid_o = pipe_vld_q[LATENCY-1];
  assign data_rdata_o  = pipe_dat_q[LATENCY-1];
  assign rd_out        = pipe_tag_q[LATENCY-1];
  assign data_err_o    = werr_q | pipe_err_q[LATENCY-1];

endmodule
